// File: rtl/tlc_pkg.sv
// Shared defaults and elaboration-time parameter checks for the traffic-light
// sensor conditioner.
package tlc_pkg;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int SERVE_CYCLES_DEF = 3;
  localparam int MAX_WAIT_DEF     = 10;
  localparam int CNT_W_DEF        = 4;

  // Every counter limit must be representable in CNT_W bits; debounce needs at least one sample.
  function automatic bit params_ok(int deb, int serve, int max_wait, int cnt_w);
    int lim;
    if (cnt_w < 1 || cnt_w > 30) return 1'b0;
    lim = (1 << cnt_w) - 1;
    return (deb >= 1) && (deb <= lim) &&
           (serve >= 0) && (serve <= lim) &&
           (max_wait >= 0) && (max_wait <= lim);
  endfunction

endpackage

// File: rtl/tlc_sensor_chan.sv
// One sensor channel: synchronizer, debounce, serve-gated request latch and
// starvation watchdog.
module tlc_sensor_chan
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int SERVE_CYCLES = SERVE_CYCLES_DEF,
  parameter int MAX_WAIT     = MAX_WAIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic g,
  output logic req,
  output logic det,
  output logic starve
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] SERVE_C  = CNT_W'(SERVE_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_C   = CNT_W'(MAX_WAIT);

  logic [1:0]       sync_q, sync_d;
  logic             det_q, det_d;
  logic             req_q, req_d;
  logic             starve_q, starve_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             s;
  logic             clr;

  always_comb begin
    sync_d      = {sync_q[0], raw};
    s           = sync_q[1];
    det_d       = det_q;
    deb_cnt_d   = '0;
    serve_cnt_d = '0;
    wait_cnt_d  = '0;

    // The edge that would bring the count to DEB_CYCLES flips det instead.
    if (s != det_q) begin
      if (deb_cnt_q == DEB_LAST) det_d = s;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end

    if (g) serve_cnt_d = (serve_cnt_q == SERVE_C) ? serve_cnt_q : serve_cnt_q + 1'b1;

    clr   = (serve_cnt_q == SERVE_C) & ~det_q;
    req_d = det_q | (req_q & ~clr);

    if (req_q & ~g) wait_cnt_d = (wait_cnt_q == WAIT_C) ? wait_cnt_q : wait_cnt_q + 1'b1;

    starve_d = (wait_cnt_q == WAIT_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      det_q       <= 1'b0;
      req_q       <= 1'b0;
      starve_q    <= 1'b0;
      deb_cnt_q   <= '0;
      serve_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      det_q       <= det_d;
      req_q       <= req_d;
      starve_q    <= starve_d;
      deb_cnt_q   <= deb_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req    = req_q;
  assign det    = det_q;
  assign starve = starve_q;

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Two independent sensor channels feeding request levels x/y to the
// traffic-light controller.
module tlc_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int SERVE_CYCLES = SERVE_CYCLES_DEF,
  parameter int MAX_WAIT     = MAX_WAIT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw1,
  input  logic raw2,
  input  logic g1,
  input  logic g2,
  output logic x,
  output logic y,
  output logic det1,
  output logic det2,
  output logic starve1,
  output logic starve2
);

  if (!params_ok(DEB_CYCLES, SERVE_CYCLES, MAX_WAIT, CNT_W)) begin : g_bad_params
    $error("tlc_sensor_conditioner: counter limit out of range for CNT_W");
  end

  tlc_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SERVE_CYCLES(SERVE_CYCLES),
    .MAX_WAIT    (MAX_WAIT),
    .CNT_W       (CNT_W)
  ) u_chan1 (
    .clk   (clk),
    .reset (reset),
    .raw   (raw1),
    .g     (g1),
    .req   (x),
    .det   (det1),
    .starve(starve1)
  );

  tlc_sensor_chan #(
    .DEB_CYCLES  (DEB_CYCLES),
    .SERVE_CYCLES(SERVE_CYCLES),
    .MAX_WAIT    (MAX_WAIT),
    .CNT_W       (CNT_W)
  ) u_chan2 (
    .clk   (clk),
    .reset (reset),
    .raw   (raw2),
    .g     (g2),
    .req   (y),
    .det   (det2),
    .starve(starve2)
  );

endmodule
